// File: rtl/number_sprite_reader_pkg.sv
// Shared constants and types for the digit sprite ROMs and their raster reader.
// The ROMs and the reader must agree on geometry, depth and key colour.
package number_sprite_reader_pkg;

    localparam int NUM_W = 20;
    localparam int NUM_H = 20;
    localparam int NUM_DEPTH = NUM_W * NUM_H;
    localparam int NUM_ADDR_W = $clog2(NUM_DEPTH);
    localparam logic [7:0] NUM_KEY = 8'h00;
    localparam int COORD_X_W = 10;
    localparam int COORD_Y_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRAWING,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Multiplier-free ROM address generator for a scaled, row-major sprite.
// Tracks column, pixel/line repeat counters and the running row base.
module sprite_addr_gen
    import number_sprite_reader_pkg::*;
#(
    parameter int SPRITE_W = NUM_W,
    parameter int SPRITE_H = NUM_H,
    parameter int ADDR_W = 10,
    parameter int SCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic              line_end,
    output logic [ADDR_W-1:0] addr,
    output logic              last_row
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam logic SUB_LAST = 1'(SCALE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPRITE_W);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic              sub_px;
    logic              sub_line;

    assign addr = row_base + ADDR_W'(col);
    assign last_row = line_end && (sub_line == SUB_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            sub_px   <= 1'b0;
            sub_line <= 1'b0;
        end else if (step) begin
            if (sub_px == SUB_LAST) begin
                sub_px <= 1'b0;
                if (col != COL_LAST) begin
                    col <= col + 1'b1;
                end
            end else begin
                sub_px <= sub_px + 1'b1;
            end
        end else if (line_end) begin
            col    <= '0;
            sub_px <= 1'b0;
            if (sub_line == SUB_LAST) begin
                sub_line <= 1'b0;
                // Final row keeps its base so the address stays inside the ROM.
                if (row != ROW_LAST) begin
                    row      <= row + 1'b1;
                    row_base <= row_base + ROW_STEP;
                end
            end else begin
                sub_line <= sub_line + 1'b1;
            end
        end
    end

endmodule

// File: rtl/number_sprite_reader.sv
// Raster-side reader for the digit sprite ROMs: follows the beam, drives the
// ROM address inside the sprite box and returns a keyed, latency-aligned pixel.
module number_sprite_reader
    import number_sprite_reader_pkg::*;
#(
    parameter int SPRITE_W = NUM_W,
    parameter int SPRITE_H = NUM_H,
    parameter int ADDR_W = 10,
    parameter int SCALE = 1,
    parameter logic [7:0] KEY_COLOR = NUM_KEY,
    parameter int X_W = COORD_X_W,
    parameter int Y_W = COORD_Y_W
) (
    input  logic              i_clk2,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic              i_enable,
    input  logic              i_de,
    input  logic [X_W-1:0]    i_x,
    input  logic [Y_W-1:0]    i_y,
    input  logic [X_W-1:0]    i_pos_x,
    input  logic [Y_W-1:0]    i_pos_y,
    output logic [ADDR_W-1:0] o_numberaddr,
    input  logic [7:0]        i_numberdata,
    output logic [7:0]        o_pixel,
    output logic              o_pixel_valid,
    output logic              o_busy
);

    localparam int XE = X_W + 1;
    localparam int YE = Y_W + 1;
    localparam logic [X_W:0] BOX_W = XE'(SPRITE_W * SCALE);
    localparam logic [Y_W:0] BOX_H = YE'(SPRITE_H * SCALE);

    state_t state;
    state_t state_nx;

    logic [X_W-1:0]    pos_x;
    logic [Y_W-1:0]    pos_y;
    logic [X_W:0]      x_ext;
    logic [X_W:0]      x_lo;
    logic [X_W:0]      x_hi;
    logic [Y_W:0]      y_ext;
    logic [Y_W:0]      y_lo;
    logic [Y_W:0]      y_hi;
    logic              in_box;
    logic              active;
    logic              step;
    logic              line_end;
    logic              last_row;
    logic              in_box_d1;
    logic              in_box_d2;
    logic              opaque;
    logic [ADDR_W-1:0] gen_addr;

    // One extra bit keeps boxes near the coordinate limit from wrapping.
    assign x_ext = {1'b0, i_x};
    assign x_lo  = {1'b0, pos_x};
    assign x_hi  = x_lo + BOX_W;
    assign y_ext = {1'b0, i_y};
    assign y_lo  = {1'b0, pos_y};
    assign y_hi  = y_lo + BOX_H;

    assign in_box = i_de
                 && (x_ext >= x_lo) && (x_ext < x_hi)
                 && (y_ext >= y_lo) && (y_ext < y_hi);

    assign active   = (state == ARMED) || (state == DRAWING);
    assign step     = active && in_box && !i_frame_start;
    assign line_end = (state == DRAWING) && !i_frame_start
                   && in_box_d1 && !in_box;
    assign opaque   = in_box_d2 && (i_numberdata != KEY_COLOR);
    assign o_busy   = active;

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W),
        .SCALE    (SCALE)
    ) u_addr_gen (
        .clk      (i_clk2),
        .rst      (i_rst),
        .clear    (i_frame_start),
        .step     (step),
        .line_end (line_end),
        .addr     (gen_addr),
        .last_row (last_row)
    );

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (i_frame_start) begin
            state_nx = i_enable ? ARMED : IDLE;
        end else begin
            case (state)
                ARMED:   if (in_box) state_nx = DRAWING;
                DRAWING: if (last_row) state_nx = DONE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            pos_x         <= '0;
            pos_y         <= '0;
            o_numberaddr  <= '0;
            in_box_d1     <= 1'b0;
            in_box_d2     <= 1'b0;
            o_pixel       <= 8'h00;
            o_pixel_valid <= 1'b0;
        end else begin
            if (i_frame_start) begin
                pos_x <= i_pos_x;
                pos_y <= i_pos_y;
            end
            if (step) begin
                o_numberaddr <= gen_addr;
            end
            in_box_d1     <= step;
            in_box_d2     <= in_box_d1;
            o_pixel_valid <= opaque;
            o_pixel       <= opaque ? i_numberdata : 8'h00;
        end
    end

endmodule

// File: tb/tb_number_sprite_reader.sv
// Bench for number_sprite_reader: SCALE=1 and SCALE=2 instances share the
// stimulus and are checked each cycle against a behavioural sprite model.
module tb_number_sprite_reader;

    localparam int W = 20;
    localparam int KEY = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs;
    logic       en;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] addr1;
    logic [9:0] addr2;
    logic [7:0] rom1;
    logic [7:0] rom2;
    logic [7:0] pix1;
    logic [7:0] pix2;
    logic       val1;
    logic       val2;
    logic       busy1;
    logic       busy2;

    always #5 clk = ~clk;

    number_sprite_reader #(.SCALE(1)) dut1 (
        .i_clk2(clk), .i_rst(rst), .i_frame_start(fs), .i_enable(en),
        .i_de(de), .i_x(x), .i_y(y), .i_pos_x(px), .i_pos_y(py),
        .o_numberaddr(addr1), .i_numberdata(rom1), .o_pixel(pix1),
        .o_pixel_valid(val1), .o_busy(busy1)
    );

    number_sprite_reader #(.SCALE(2)) dut2 (
        .i_clk2(clk), .i_rst(rst), .i_frame_start(fs), .i_enable(en),
        .i_de(de), .i_x(x), .i_y(y), .i_pos_x(px), .i_pos_y(py),
        .o_numberaddr(addr2), .i_numberdata(rom2), .o_pixel(pix2),
        .o_pixel_valid(val2), .o_busy(busy2)
    );

    // Digit ROMs: one-cycle synchronous read, content = address low byte.
    always @(posedge clk) begin
        rom1 <= addr1[7:0];
        rom2 <= addr2[7:0];
    end

    // Model: 0 idle, 1 armed, 2 drawing, 3 done.
    int m_st[2]    = '{0, 0};
    int m_addr[2]  = '{0, 0};
    int m_rom[2]   = '{0, 0};
    int m_pix[2]   = '{0, 0};
    int m_seg[2]   = '{0, 0};
    int m_lines[2] = '{0, 0};
    bit m_ib1[2]   = '{0, 0};
    bit m_ib2[2]   = '{0, 0};
    bit m_val[2]   = '{0, 0};
    int m_px = 0;
    int m_py = 0;
    int hx[3] = '{0, 0, 0};
    int hy[3] = '{0, 0, 0};
    bit hrst = 1'b0;
    bit started = 1'b0;

    int phase = 0;
    int prev_phase = 0;
    int vcount = 0;
    int checks = 0;
    int errors = 0;

    task automatic model_step();
        int s;
        int orom;
        int c;
        bit inb;
        bit acted;
        bit nv;
        for (int d = 0; d < 2; d++) begin
            s = d + 1;
            orom = m_rom[d];
            nv = m_ib2[d] && (orom != KEY);
            m_rom[d] = m_addr[d] % 256;
            if (rst) begin
                m_pix[d] = 0;
                m_val[d] = 0;
                m_st[d] = 0;
                m_addr[d] = 0;
                m_ib1[d] = 0;
                m_ib2[d] = 0;
                m_seg[d] = 0;
                m_lines[d] = 0;
            end else begin
                m_val[d] = nv;
                m_pix[d] = nv ? orom : 0;
                m_ib2[d] = m_ib1[d];
                inb = de && int'(x) >= m_px && int'(x) < m_px + W * s
                      && int'(y) >= m_py && int'(y) < m_py + W * s;
                acted = 0;
                if (fs) begin
                    m_st[d] = en ? 1 : 0;
                    m_seg[d] = 0;
                    m_lines[d] = 0;
                end else if (m_st[d] == 1 || m_st[d] == 2) begin
                    if (inb) begin
                        c = m_seg[d] / s;
                        if (c > W - 1) c = W - 1;
                        m_addr[d] = (m_lines[d] / s) * W + c;
                        m_seg[d]++;
                        acted = 1;
                        m_st[d] = 2;
                    end else if (m_ib1[d]) begin
                        m_lines[d]++;
                        m_seg[d] = 0;
                        if (m_lines[d] == W * s) m_st[d] = 3;
                    end
                end
                m_ib1[d] = acted;
            end
        end
        if (!rst && fs) begin
            m_px = int'(px);
            m_py = int'(py);
        end
        hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = int'(x);
        hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = int'(y);
        hrst = rst;
        started = 1'b1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic compare_step();
        if (!started) return;
        chk("addr1", int'(addr1), m_addr[0]);
        chk("pix1", int'(pix1), m_pix[0]);
        chk("val1", int'(val1), int'(m_val[0]));
        chk("busy1", int'(busy1), int'(m_st[0] == 1 || m_st[0] == 2));
        chk("addr2", int'(addr2), m_addr[1]);
        chk("pix2", int'(pix2), m_pix[1]);
        chk("val2", int'(val2), int'(m_val[1]));
        chk("busy2", int'(busy2), int'(m_st[1] == 1 || m_st[1] == 2));
        if (hrst) begin
            chk("rst_addr1", int'(addr1), 0);
            chk("rst_pix1", int'(pix1), 0);
            chk("rst_val1", int'(val1), 0);
            chk("rst_busy1", int'(busy1), 0);
            chk("rst_addr2", int'(addr2), 0);
            chk("rst_busy2", int'(busy2), 0);
        end
        if (phase == 1) begin
            if (hx[0] == 100 && hy[0] == 50) chk("lit_a0", int'(addr1), 0);
            if (hx[0] == 119 && hy[0] == 69) chk("lit_a399", int'(addr1), 399);
            if (hx[2] == 100 && hy[2] == 50) begin
                chk("lit_p0", int'(pix1), 0);
                chk("lit_v0", int'(val1), 0);
            end
            if (hx[2] == 119 && hy[2] == 69) begin
                chk("lit_p8f", int'(pix1), 'h8F);
                chk("lit_v8f", int'(val1), 1);
            end
        end
        if (phase == 2) begin
            if (hx[0] == 1 && hy[0] == 0) chk("lit_s2_hold", int'(addr2), 0);
            if (hx[0] == 2 && hy[0] == 0) chk("lit_s2_col1", int'(addr2), 1);
            if (hx[0] == 0 && hy[0] == 1) chk("lit_s2_rep", int'(addr2), 0);
            if (hx[0] == 0 && hy[0] == 2) chk("lit_s2_a20", int'(addr2), 20);
        end
        if (phase == 3) begin
            if (hx[0] == 639 && hy[0] == 50) chk("lit_clip9", int'(addr1), 9);
            if (hx[0] == 630 && hy[0] == 51) chk("lit_clip20", int'(addr1), 20);
        end
        if (phase == 5) begin
            if (hx[0] == 40 && hy[0] == 20) chk("lit_rs_a0", int'(addr1), 0);
            if (hx[0] == 41 && hy[0] == 21) chk("lit_rs_a21", int'(addr1), 21);
            if (hx[0] == 42 && hy[0] == 22) chk("lit_rs2_a21", int'(addr2), 21);
        end
        if (phase == 6) begin
            if (hx[0] == 300 && hy[0] == 200) chk("lit_mid_a0", int'(addr1), 0);
            if (hx[0] == 301 && hy[0] == 200) chk("lit_mid_a1", int'(addr1), 1);
        end
        if (phase == 7 && (val1 || val2)) vcount++;
        if (phase != prev_phase) begin
            if (prev_phase == 1) chk("busy1_done_y69", int'(busy1), 0);
            if (prev_phase == 2) chk("busy2_done_y39", int'(busy2), 0);
            if (prev_phase == 7) chk("en0_valid_cnt", vcount, 0);
            prev_phase = phase;
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) compare_step();

    task automatic drive(input bit f, input bit e, input bit d,
                         input int xx, input int yy);
        fs = f;
        en = e;
        de = d;
        x = xx[9:0];
        y = yy[9:0];
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int nx, input int ny, input bit e);
        px = nx[9:0];
        py = ny[9:0];
        drive(1'b1, e, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic sweep(input int y0, input int y1, input int x0,
                         input int x1, input bit glitch);
        bit d;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                d = (xx < 640) && (yy < 480);
                if (glitch && $urandom_range(0, 15) == 0) d = 1'b0;
                drive(1'b0, 1'b0, d, xx, yy);
            end
            drive(1'b0, 1'b0, 1'b0, x1, yy);
        end
    endtask

    initial begin
        int rx;
        int ry;
        rst = 1'b1;
        fs = 1'b0; en = 1'b0; de = 1'b0;
        x = '0; y = '0; px = '0; py = '0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0, 0);

        phase = 1;
        frame(100, 50, 1'b1);
        sweep(49, 71, 97, 143, 1'b0);

        phase = 2;
        frame(0, 0, 1'b1);
        sweep(0, 41, 0, 43, 1'b0);

        phase = 3;
        frame(630, 50, 1'b1);
        sweep(49, 71, 627, 660, 1'b0);

        phase = 4;
        frame(40, 20, 1'b1);
        sweep(19, 26, 37, 83, 1'b0);
        for (int xx = 37; xx < 50; xx++) drive(1'b0, 1'b0, 1'b1, xx, 27);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 50, 27);
        rst = 1'b0;

        phase = 5;
        frame(40, 20, 1'b1);
        sweep(19, 61, 37, 83, 1'b0);

        phase = 6;
        frame(100, 50, 1'b1);
        sweep(49, 54, 97, 143, 1'b0);
        for (int xx = 97; xx <= 110; xx++) drive(1'b0, 1'b0, 1'b1, xx, 55);
        px = 10'd300;
        py = 10'd200;
        drive(1'b1, 1'b1, 1'b1, 111, 55);
        sweep(199, 241, 297, 343, 1'b0);

        phase = 7;
        frame(10, 10, 1'b0);
        sweep(9, 51, 7, 53, 1'b0);

        phase = 8;
        repeat (4) begin
            rx = int'($urandom_range(0, 1010));
            ry = int'($urandom_range(0, 470));
            frame(rx, ry, $urandom_range(0, 3) != 0);
            sweep((ry > 0) ? ry - 1 : 0, ry + 41,
                  (rx > 3) ? rx - 3 : 0, (rx + 43 > 1023) ? 1023 : rx + 43,
                  1'b1);
        end

        phase = 9;
        repeat (4) drive(1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
